divrem_seq: RTL and testbench

- Sequential signed divider: the inverse of the 8x8 multiply-accumulate datapath.
- Given a 16-bit accumulator value and an 8-bit operand, it recovers quotient and remainder such that dividend = quotient*divisor + remainder.
- Sits beside the MAC units and de-scales accumulated results back to 8-bit operands.
- Radix-2 restoring iteration, one bit per cycle, valid/ready on both sides.

---
 rtl/divrem_seq.sv | 179 +++++++++++++++++
 tb/tb_divrem_seq.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/divrem_seq.sv
// divrem_seq: sequential signed divider, radix-2 restoring, one quotient bit
// per cycle. Divides a 2*DW-bit signed dividend by a DW-bit signed divisor and
// returns a truncated quotient (saturated to DW bits) and a remainder carrying
// the dividend's sign.
//
// Optional feature: define DIVREM_FAST_ZERO_EN to skip the iteration when the
// divisor or the dividend is zero at accept (IDLE goes straight to FIX).
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operands present
//   in_ready   block can accept operands (high only in IDLE)
//   dividend   signed dividend, 2*DW bits
//   divisor    signed divisor, DW bits
//   out_valid  result present
//   out_ready  consumer accepts result
//   quotient   signed quotient, DW bits
//   remainder  signed remainder, DW bits
//   ovf        quotient saturated
//   dz         divide by zero
module divrem_seq #(
    parameter int unsigned DW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*DW-1:0]   dividend,
    input  logic [DW-1:0]     divisor,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     quotient,
    output logic [DW-1:0]     remainder,
    output logic              ovf,
    output logic              dz
);

    localparam int unsigned W2 = 2 * DW;
    localparam int unsigned CW = $clog2(W2);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [W2-1:0] LIM_POS = W2'((1 << (DW - 1)) - 1);
    localparam logic [W2-1:0] LIM_NEG = W2'(1 << (DW - 1));
    localparam logic [DW-1:0] SAT_POS = {1'b0, {(DW - 1){1'b1}}};
    localparam logic [DW-1:0] SAT_NEG = {1'b1, {(DW - 1){1'b0}}};

    logic [1:0]     state, state_nxt;
    logic [CW-1:0]  cnt;
    logic           neg_dd, sign_q, dz_r;
    logic [DW-1:0]  dd_lo;
    logic [W2-1:0]  qmag;
    logic [DW:0]    mag_dv;
    logic [W2:0]    prem;

    logic           accept;
    logic [W2-1:0]  dd_abs;
    logic [DW:0]    dv_ext, dv_abs;
    logic [W2+1:0]  rem_sh, dv_wide;
    logic           take;
    logic [W2:0]    prem_nxt;
    logic [W2-1:0]  qmag_nxt;
    logic           ovf_c;
    logic [DW-1:0]  q_lo, r_lo;

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (in_valid && in_ready) begin
`ifdef DIVREM_FAST_ZERO_EN
                    if ((divisor == '0) || (dividend == '0)) state_nxt = S_FIX;
                    else                                     state_nxt = S_CALC;
`else
                    state_nxt = S_CALC;
`endif
                end
            end
            S_CALC:  if (cnt == CW'(W2 - 1)) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_DONE;
            S_DONE:  if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand magnitudes, one restoring step, and sign/range fix-up
    always_comb begin
        accept   = in_valid && in_ready;
        dd_abs   = dividend[W2-1] ? W2'(-dividend) : dividend;
        dv_ext   = {divisor[DW-1], divisor};
        dv_abs   = dv_ext[DW] ? (DW+1)'(-dv_ext) : dv_ext;

        // Full-width shift keeps every partial-remainder bit in the compare
        rem_sh   = {prem, qmag[W2-1]};
        dv_wide  = (W2+2)'(mag_dv);
        take     = (rem_sh >= dv_wide);
        prem_nxt = take ? (W2+1)'(rem_sh - dv_wide) : (W2+1)'(rem_sh);
        qmag_nxt = {qmag[W2-2:0], take};

        // Negative quotients may reach one step further than positive ones
        ovf_c    = sign_q ? (qmag > LIM_NEG) : (qmag > LIM_POS);
        q_lo     = sign_q ? DW'(-qmag[DW-1:0]) : qmag[DW-1:0];
        r_lo     = neg_dd ? DW'(-prem[DW-1:0]) : prem[DW-1:0];
    end

    // State register and handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt == S_IDLE);
            if (state == S_FIX)
                out_valid <= 1'b1;
            else if ((state == S_DONE) && out_ready)
                out_valid <= 1'b0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            neg_dd    <= 1'b0;
            sign_q    <= 1'b0;
            dz_r      <= 1'b0;
            dd_lo     <= '0;
            qmag      <= '0;
            mag_dv    <= '0;
            prem      <= '0;
            quotient  <= '0;
            remainder <= '0;
            ovf       <= 1'b0;
            dz        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        neg_dd <= dividend[W2-1];
                        sign_q <= dividend[W2-1] ^ divisor[DW-1];
                        dz_r   <= (divisor == '0);
                        dd_lo  <= dividend[DW-1:0];
                        qmag   <= dd_abs;
                        mag_dv <= dv_abs;
                        prem   <= '0;
                        cnt    <= '0;
                    end
                end
                S_CALC: begin
                    prem <= prem_nxt;
                    qmag <= qmag_nxt;
                    cnt  <= cnt + CW'(1);
                end
                S_FIX: begin
                    if (dz_r) begin
                        quotient  <= neg_dd ? SAT_NEG : SAT_POS;
                        remainder <= dd_lo;
                        ovf       <= 1'b0;
                        dz        <= 1'b1;
                    end else begin
                        quotient  <= ovf_c ? (sign_q ? SAT_NEG : SAT_POS) : q_lo;
                        remainder <= r_lo;
                        ovf       <= ovf_c;
                        dz        <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divrem_seq.sv
// Self-checking bench for divrem_seq: directed cases from the feature list plus
// random operands, compared against plain integer division in the bench.
module tb_divrem_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        ovf;
    logic        dz;

    int total = 0;
    int bad   = 0;

    divrem_seq #(.DW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .ovf       (ovf),
        .dz        (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference: integer division truncates toward zero, % follows dividend sign
    task automatic model(input int a, input int b, output logic [7:0] q, output logic [7:0] r,
                         output logic o, output logic z);
        int qt, rt;
        if (b == 0) begin
            z = 1'b1; o = 1'b0;
            r = 8'(a);
            q = (a >= 0) ? 8'(127) : 8'(-128);
        end else begin
            z = 1'b0;
            qt = a / b;
            rt = a % b;
            o = (qt > 127) || (qt < -128);
            q = o ? ((qt > 0) ? 8'(127) : 8'(-128)) : 8'(qt);
            r = 8'(rt);
        end
    endtask

    // Present operands for one edge and confirm they were taken
    task automatic accept(input int a, input int b);
        for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
        @(negedge clk);
        dividend = 16'(a);
        divisor  = 8'(b);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
        check("accepted_in_ready_low", 32'(in_ready), 32'd0);
    endtask

    // Wait for the result, check it, hold it for 'hold' cycles, then handshake
    task automatic collect(input string tag, input int a, input int b, input int hold,
                           input logic inject);
        logic [7:0] eq, er;
        logic       eo, ez;
        int         lat;
        logic [7:0] q0, r0;
        model(a, b, eq, er, eo, ez);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
`ifdef DIVREM_FAST_ZERO_EN
        if (a != 0 && b != 0) check({tag, "_latency"}, 32'(lat), 32'd17);
`else
        check({tag, "_latency"}, 32'(lat), 32'd17);
`endif
        check({tag, "_quotient"},  32'(quotient),  32'(eq));
        check({tag, "_remainder"}, 32'(remainder), 32'(er));
        check({tag, "_ovf"},       32'(ovf),       32'(eo));
        check({tag, "_dz"},        32'(dz),        32'(ez));
        check({tag, "_in_ready"},  32'(in_ready),  32'd0);
        q0 = quotient;
        r0 = remainder;
        if (inject) begin
            @(negedge clk);
            dividend = 16'd50;
            divisor  = 8'd5;
            in_valid = 1'b1;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_ready"}, 32'(in_ready),  32'd0);
            check({tag, "_hold_q"},     32'(quotient),  32'(q0));
            check({tag, "_hold_r"},     32'(remainder), 32'(r0));
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_hs_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_hs_ready"}, 32'(in_ready),  32'd1);
        check({tag, "_hs_q_kept"}, 32'(quotient), 32'(q0));
    endtask

    task automatic divide(input string tag, input int a, input int b);
        accept(a, b);
        collect(tag, a, b, 0, 1'b0);
    endtask

    initial begin
        int a, b;
        int seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        #12;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_quotient",  32'(quotient),  32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_ovf",       32'(ovf),       32'd0);
        check("rst_dz",        32'(dz),        32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        divide("1000_7",     1000,    7);
        divide("700_7",      700,     7);
        divide("m100_7",     -100,    7);
        divide("100_m7",     100,    -7);
        divide("m100_m7",    -100,   -7);
        divide("300_0",      300,     0);
        divide("m5_0",       -5,      0);
        divide("m32768_m1",  -32768, -1);
        divide("m128_m1",    -128,   -1);
        divide("m16384_127", -16384, 127);
        divide("0_9",        0,       9);
        divide("32767_m128", 32767, -128);

        // Back-pressure with a competing request that must wait for the handshake
        accept(1000, 7);
        collect("bp", 1000, 7, 10, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_next_accepted", 32'(in_ready), 32'd0);
        collect("bp_50_5", 50, 5, 0, 1'b0);

        // Reset in the middle of CALC abandons the division
        accept(-100, 7);
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_quotient",  32'(quotient),  32'd0);
        check("midrst_remainder", 32'(remainder), 32'd0);
        check("midrst_in_ready",  32'(in_ready),  32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("midrst_no_result", 32'(seen), 32'd0);
        divide("81_9", 81, 9);

        // Random operands, mixing full-range and small dividends
        for (int i = 0; i < 40; i++) begin
            a = int'($signed(16'($urandom)));
            if (i % 3 == 0) a = int'($signed(8'($urandom)));
            b = int'($signed(8'($urandom)));
            if (i % 7 == 0) b = 0;
            divide("rand", a, b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute guard against a stalled run
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
